icache_mem_bridge: RTL



---
 rtl/icache_mem_bridge_pkg.sv | 24 ++
 rtl/icache_mem_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/icache_mem_bridge_pkg.sv
// Shared definitions for the instruction-cache to RIB bridge: FSM encoding,
// default line geometry and RIB bus constants.
package icache_mem_bridge_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic RIB_REQ      = 1'b1;
  localparam logic RIB_IDLE     = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WCHK   = 3'd2,
    RMW_RD = 3'd3,
    WR     = 3'd4,
    RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/icache_mem_bridge.sv
// Splits cache-line refills and write-backs into single-word RIB transfers;
// partial-byte words are completed by read-modify-write.
module icache_mem_bridge
  import icache_mem_bridge_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MemAddrBus-1:0]   cache_addr_i,
  input  logic [4*LINE_WORDS-1:0] cache_byte_en_i,
  input  logic [32*LINE_WORDS-1:0] cache_wdata_i,
  input  logic                    cache_read_i,
  input  logic                    cache_write_i,
  output logic [32*LINE_WORDS-1:0] cache_rdata_o,
  output logic                    cache_rdata_valid_o,
  output logic                    cache_waitrequest_o,
  output logic [MemAddrBus-1:0]   mem_addr_o,
  output logic [MemBus-1:0]       mem_data_o,
  input  logic [MemBus-1:0]       mem_data_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  input  logic                    mem_gnt_i,
  output logic                    protocol_err_o
);

  localparam int KW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF_W = KW + 2;
  localparam logic [KW-1:0] K_LAST = KW'(LINE_WORDS - 1);

  state_e                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [31:OFF_W]            base_q, base_d;
  logic [32*LINE_WORDS-1:0]   wline_q, wline_d;
  logic [4*LINE_WORDS-1:0]    be_q, be_d;
  logic [32*LINE_WORDS-1:0]   rdata_q, rdata_d;
  logic [31:0]                wword_q, wword_d;
  logic                       perr_q, perr_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic                       valid_q, valid_d;
  logic [MemAddrBus-1:0]      addr_q, addr_d;
  logic [MemBus-1:0]          data_q, data_d;
  logic                       advance;
  logic [31:0]                wd_k;
  logic [3:0]                 be_k;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^cache_addr_i[OFF_W-1:0];

  function automatic logic [31:0] merge_word(input logic [31:0] wd, input logic [31:0] rd,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      r[8*j +: 8] = be[j] ? wd[8*j +: 8] : rd[8*j +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    wline_d = wline_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    wword_d = wword_q;
    perr_d  = perr_q;
    advance = 1'b0;
    wd_k    = wline_q[k_q*32 +: 32];
    be_k    = be_q[k_q*4 +: 4];

    case (state_q)
      IDLE: begin
        if (cache_read_i || cache_write_i) begin
          base_d  = cache_addr_i[31:OFF_W];
          wline_d = cache_wdata_i;
          be_d    = cache_byte_en_i;
          k_d     = '0;
          // A simultaneous read/write is served as a read and flagged.
          state_d = cache_read_i ? RD : WCHK;
          if (cache_read_i && cache_write_i) perr_d = 1'b1;
        end
      end
      RD: begin
        if (mem_gnt_i) begin
          rdata_d[k_q*32 +: 32] = mem_data_i;
          if (k_q == K_LAST) state_d = RESP;
          else               k_d = k_q + KW'(1);
        end
      end
      RESP: state_d = IDLE;
      WCHK: begin
        if (be_k == 4'h0) begin
          advance = 1'b1;
        end else if (be_k == 4'hF) begin
          wword_d = wd_k;
          state_d = WR;
        end else begin
          state_d = RMW_RD;
        end
      end
      RMW_RD: begin
        if (mem_gnt_i) begin
          wword_d = merge_word(wd_k, mem_data_i, be_k);
          state_d = WR;
        end
      end
      WR: begin
        if (mem_gnt_i) advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (k_q == K_LAST) begin
        state_d = IDLE;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = WCHK;
      end
    end

    // Bus outputs are decoded from the next state so they appear registered.
    req_d   = (state_d == RD) || (state_d == RMW_RD) || (state_d == WR);
    we_d    = (state_d == WR) ? WriteEnable : WriteDisable;
    addr_d  = req_d ? {base_d, k_d, 2'b00} : '0;
    data_d  = (state_d == WR) ? wword_d : '0;
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      wline_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      wword_q <= '0;
      perr_q  <= 1'b0;
      req_q   <= RIB_IDLE;
      we_q    <= WriteDisable;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      wword_q <= wword_d;
      perr_q  <= perr_d;
      req_q   <= req_d ? RIB_REQ : RIB_IDLE;
      we_q    <= we_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign cache_waitrequest_o = (state_q != IDLE);
  assign cache_rdata_o       = rdata_q;
  assign cache_rdata_valid_o = valid_q;
  assign mem_addr_o          = addr_q;
  assign mem_data_o          = data_q;
  assign mem_req_o           = req_q;
  assign mem_we_o            = we_q;
  assign protocol_err_o      = perr_q;

endmodule
